cic_interp: RTL and testbench
=============================

Name: cic_interp

Overview:
- Cascaded integrator-comb interpolator: the transmit-side counterpart of the team's CIC decimator.
- Accepts low-rate samples through a ready/valid handshake and produces one output sample per enabled clock, interpolating by a programmable ratio R (1..MAXRATE).
- Sits between the baseband/DUC source and the high-rate NCO mixer.
- Structure: N comb stages (differential delay M) at the input rate, then a zero-stuffing upsampler, then N integrators at the output rate.

Parameters:
- DATAIN_WIDTH, 16, input sample width (two's complement).
- DATAOUT_WIDTH, DATAIN_WIDTH, output sample width; must be <= internal width W.
- M, 2, comb differential delay.
- N, 5, number of comb and integrator stages.
- MAXRATE, 64, maximum interpolation ratio; power of two.
- RATE_WIDTH, log2(MAXRATE)+1, width of rate_i.
- bitgrowth, N*log2(M)+(N-1)*log2(MAXRATE), internal growth. Default is 29. Internal width W = DATAIN_WIDTH+bitgrowth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  clock enable; all state advances only when high
- rate_i  in  RATE_WIDTH  interpolation ratio R
- data_i  in  DATAIN_WIDTH  input sample
- val_i  in  1  input sample valid
- rdy_o  out  1  block requests an input sample this cycle
- data_o  out  DATAOUT_WIDTH  output sample
- val_o  out  1  output sample valid
- underrun_o  out  1  one-cycle pulse: an input slot passed without valid data

Behaviour:
- Reset (rst_i=1 at a clock edge; dominates en_i):
  - All comb delays, comb pipes, the upsampler register and the integrators are cleared to 0.
  - cnt=0; rate_q loads clamp(rate_i).
  - val_o=0, underrun_o=0, data_o=0, rdy_o=1.
- Rate clamp: rate_i=0 is treated as 1; rate_i>MAXRATE is treated as MAXRATE.
- Phase counter:
  - cnt runs 0..rate_q-1 and increments only on en_i cycles.
  - At the edge where cnt==rate_q-1, cnt wraps to 0 and rate_q reloads clamp(rate_i). Rate changes therefore take effect only at the wrap.
  - With rate_q=1, cnt stays 0.
- Handshake:
  - rdy_o = (cnt==0), combinational from registers.
  - A slot is an edge with en_i=1 and cnt==0.
  - At a slot, x = sign-extend(data_i) to W if val_i=1, otherwise x=0 and underrun_o=1 on the next cycle.
  - val_i on non-slot cycles is ignored.
  - val_i with en_i=0 is not accepted and raises no underrun.
- Comb chain (updates only at slots):
  - Stage 0: d[0][0]<=x, d[0][j]<=d[0][j-1], pipe[0]<=x-d[0][M-1].
  - Stage i: d[i][0]<=pipe[i-1], d[i][j]<=d[i][j-1], pipe[i]<=pipe[i-1]-d[i][M-1].
  - Right-hand sides use pre-edge values.
- Upsampler (every en_i edge): up<=pipe[N-1] at a slot, otherwise up<=0.
- Integrators (every en_i edge): integ[0]<=integ[0]+up; integ[i]<=integ[i]+integ[i-1].
- Arithmetic:
  - All W-bit, two's complement, modulo wrap. Wrap is intentional and cancels exactly.
  - No saturation and no rounding.
- Output:
  - data_o = integ[N-1][W-1 : W-DATAOUT_WIDTH] (truncation).
  - val_o registered: val_o<=en_i; 0 during reset.
- Gain: (R*M)^N / R relative to 2^bitgrowth. At R=MAXRATE with defaults, DC gain is exactly 1.
- Stall (en_i=0): cnt, comb, up and integrators hold. val_o=0 on the next cycle. rdy_o keeps its value.
- Reset mid-operation: reset is restartable from any state; the first slot is the first en_i edge after reset deasserts.

Test Plan:
- Reset: hold rst_i 3 cycles with en_i=1 -> data_o=0, val_o=0, underrun_o=0, rdy_o=1; first post-reset cycle is a slot.
- DC at max rate: defaults, rate_i=64, en_i=1, val_i=1 whenever rdy_o, data_i=1000 -> rdy_o high 1 of every 64 cycles; data_o settles to exactly 1000 after >= 6 input samples; val_o=1 every cycle.
- DC at R=32: data_i=1000 -> data_o settles to 62. Then data_i=-1000 -> data_o settles to -63 (floor truncation).
- Underrun: R=4, hold val_i=0 at one slot -> underrun_o is a single one-cycle pulse one cycle after that slot; zero is inserted; no pulse on non-slot cycles or when en_i=0.
- Rate change and stall:
  - With R=4, change rate_i to 8 mid-period -> current period still lasts 4 en_i cycles; the next gap between rdy_o pulses is 8.
  - Drop en_i for 5 cycles -> data_o and cnt frozen; val_o=0 during the stall.
- Reset mid-stream: assert rst_i during DC=1000 at R=64 -> all outputs return to their reset values next cycle; after release, output re-settles to 1000 with the same latency as from cold reset.

Source files
------------

// File: rtl/cic_interp.sv
// Cascaded integrator-comb interpolator. Low-rate samples enter through a
// ready/valid handshake, pass N comb stages at the input rate, get
// zero-stuffed by the programmable ratio R and then run through N
// integrators at the output rate. Arithmetic is W-bit modulo; the wrap in
// the integrators is cancelled exactly by the combs.
module cic_interp #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = DATAIN_WIDTH,
  parameter int M             = 2,
  parameter int N             = 5,
  parameter int MAXRATE       = 64,
  parameter int RATE_WIDTH    = $clog2(MAXRATE) + 1,
  parameter int BITGROWTH     = N * $clog2(M) + (N - 1) * $clog2(MAXRATE)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [RATE_WIDTH-1:0]    rate_i,
  input  logic [DATAIN_WIDTH-1:0]  data_i,
  input  logic                     val_i,
  output logic                     rdy_o,
  output logic [DATAOUT_WIDTH-1:0] data_o,
  output logic                     val_o,
  output logic                     underrun_o
);

  localparam int W = DATAIN_WIDTH + BITGROWTH;

  logic [RATE_WIDTH-1:0] rate_q;
  logic [RATE_WIDTH-1:0] rate_clamped;
  logic [RATE_WIDTH-1:0] cnt;
  logic                  slot;
  logic                  wrap;
  logic [W-1:0]          x;
  logic [W-1:0]          dly   [N][M];
  logic [W-1:0]          pipe  [N];
  logic [W-1:0]          comb_in [N];
  logic [W-1:0]          up;
  logic [W-1:0]          integ [N];

  // Ratio clamp: zero means no interpolation, oversized ratios saturate.
  always_comb begin
    rate_clamped = rate_i;
    if (rate_i == '0)
      rate_clamped = RATE_WIDTH'(1);
    else if (rate_i > RATE_WIDTH'(MAXRATE))
      rate_clamped = RATE_WIDTH'(MAXRATE);
  end

  assign slot  = en_i && (cnt == '0);
  assign wrap  = (cnt == rate_q - RATE_WIDTH'(1));
  assign rdy_o = (cnt == '0);

  // Accepted sample, sign-extended; an empty slot injects zero.
  always_comb begin
    x = '0;
    if (val_i)
      x = {{(W - DATAIN_WIDTH){data_i[DATAIN_WIDTH-1]}}, data_i};
  end

  // Input of each comb stage: the new sample for stage 0, else the previous pipe.
  always_comb begin
    for (int i = 0; i < N; i++)
      comb_in[i] = (i == 0) ? x : pipe[(i == 0) ? 0 : i - 1];
  end

  // Phase counter; a new ratio is only picked up when the period wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      rate_q <= rate_clamped;
    end else if (en_i) begin
      if (wrap) begin
        cnt    <= '0;
        rate_q <= rate_clamped;
      end else begin
        cnt <= cnt + RATE_WIDTH'(1);
      end
    end
  end

  // Comb chain, advanced once per input slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        pipe[i] <= '0;
        for (int j = 0; j < M; j++)
          dly[i][j] <= '0;
      end
    end else if (slot) begin
      for (int i = 0; i < N; i++) begin
        dly[i][0] <= comb_in[i];
        for (int j = 1; j < M; j++)
          dly[i][j] <= dly[i][j-1];
        pipe[i] <= comb_in[i] - dly[i][M-1];
      end
    end
  end

  // Zero-stuffing upsampler followed by the integrator cascade.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up <= '0;
      for (int i = 0; i < N; i++)
        integ[i] <= '0;
    end else if (en_i) begin
      up       <= slot ? pipe[N-1] : '0;
      integ[0] <= integ[0] + up;
      for (int i = 1; i < N; i++)
        integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Output strobe and underrun pulse, both one cycle after the edge they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_o      <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      val_o      <= en_i;
      underrun_o <= slot && !val_i;
    end
  end

  assign data_o = integ[N-1][W-1 -: DATAOUT_WIDTH];

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp with default parameters (W=45, R up to 64).
module tb_cic_interp;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [6:0]         rate;
  logic [15:0]        data_in;
  logic               val_in;
  logic               rdy;
  logic signed [15:0] data_out;
  logic               val_out;
  logic               underrun;

  int total = 0;
  int bad   = 0;
  int cold_last_bad = -1;

  cic_interp dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .rate_i     (rate),
    .data_i     (data_in),
    .val_i      (val_in),
    .rdy_o      (rdy),
    .data_o     (data_out),
    .val_o      (val_out),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs 1280 cycles of DC input at R=64 from just after reset release.
  task automatic measure_settle(output int last_bad, output int rdy_cnt, output int val_bad);
    last_bad = -1;
    rdy_cnt  = 0;
    val_bad  = 0;
    for (int i = 0; i < 1280; i++) begin
      cyc();
      if (data_out !== 16'sd1000) last_bad = i;
      if (rdy === 1'b1) rdy_cnt++;
      if (val_out !== 1'b1) val_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rate = 7'd64; data_in = 16'd1000; val_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++; if (data_out !== 16'sd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", data_out); end
      total++; if (val_out !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", val_out); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    end
    rst = 1'b0;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL first_slot_rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_dc_max();
    int lb, rc, vb;
    measure_settle(lb, rc, vb);
    cold_last_bad = lb;
    total++; if (rc != 20) begin bad++; $display("FAIL dc64_rdy_count got=%0d exp=20", rc); end
    total++; if (vb != 0) begin bad++; $display("FAIL dc64_val_gaps got=%0d exp=0", vb); end
    total++; if (lb >= 1216) begin bad++; $display("FAIL dc64_settle last_bad_cycle=%0d exp<1216", lb); end
    total++; if (data_out !== 16'sd1000) begin bad++; $display("FAIL dc64_value got=%0d exp=1000", data_out); end
  endtask

  task automatic test_reset_mid();
    int lb, rc, vb;
    rst = 1'b1;
    cyc();
    total++; if (data_out !== 16'sd0) begin bad++; $display("FAIL midrst_data got=%0d exp=0", data_out); end
    total++; if (val_out !== 1'b0) begin bad++; $display("FAIL midrst_val got=%b exp=0", val_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL midrst_underrun got=%b exp=0", underrun); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL midrst_rdy got=%b exp=1", rdy); end
    rst = 1'b0;
    measure_settle(lb, rc, vb);
    total++; if (lb != cold_last_bad) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lb, cold_last_bad); end
    total++; if (rc != 20) begin bad++; $display("FAIL midrst_rdy_count got=%0d exp=20", rc); end
    total++; if (data_out !== 16'sd1000) begin bad++; $display("FAIL midrst_value got=%0d exp=1000", data_out); end
  endtask

  task automatic test_dc_r32();
    int errs;
    rst = 1'b1; rate = 7'd32; data_in = 16'd1000; val_in = 1'b1; en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (1280) cyc();
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (data_out !== 16'sd62) errs++;
      cyc();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL dc32_pos errors=%0d last=%0d exp=62", errs, data_out); end
    data_in = 16'hFC18;  // -1000
    repeat (1280) cyc();
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (data_out !== -16'sd63) errs++;
      cyc();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL dc32_neg errors=%0d last=%0d exp=-63", errs, data_out); end
  endtask

  task automatic test_underrun();
    int pulses;
    rst = 1'b1; rate = 7'd4; data_in = 16'd1000; val_in = 1'b1; en = 1'b1;
    cyc();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (underrun !== 1'b0) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL ur_idle pulses=%0d exp=0", pulses); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ur_slot_rdy got=%b exp=1", rdy); end
    val_in = 1'b0;
    cyc();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse got=%b exp=1", underrun); end
    val_in = 1'b1;
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_single got=%b exp=0", underrun); end
    // cnt is now 2: missing valid off-slot must not pulse
    val_in = 1'b0;
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_nonslot_a got=%b exp=0", underrun); end
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_nonslot_b got=%b exp=0", underrun); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ur_slot2_rdy got=%b exp=1", rdy); end
    en = 1'b0;
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_stalled got=%b exp=0", underrun); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ur_stalled_rdy got=%b exp=1", rdy); end
    en = 1'b1; val_in = 1'b1;
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_resume got=%b exp=0", underrun); end
  endtask

  task automatic test_rate_change();
    int n;
    rst = 1'b1; rate = 7'd4; data_in = 16'd1000; val_in = 1'b1; en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    rate = 7'd8;
    n = 0;
    for (int i = 0; i < 40; i++) begin cyc(); n++; if (rdy === 1'b1) break; end
    total++; if (n != 2) begin bad++; $display("FAIL rate_old_period remaining=%0d exp=2", n); end
    n = 0;
    for (int i = 0; i < 40; i++) begin cyc(); n++; if (rdy === 1'b1) break; end
    total++; if (n != 8) begin bad++; $display("FAIL rate_new_period got=%0d exp=8", n); end
  endtask

  task automatic test_stall();
    int n, frozen_err, val_err, rdy_err;
    logic signed [15:0] held;
    rst = 1'b1; rate = 7'd64; data_in = 16'd1000; val_in = 1'b1; en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (600) cyc();  // mid-transient, cnt=24
    held = data_out;
    en = 1'b0;
    frozen_err = 0; val_err = 0; rdy_err = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (data_out !== held) frozen_err++;
      if (val_out !== 1'b0) val_err++;
      if (rdy !== 1'b0) rdy_err++;
    end
    total++; if (frozen_err != 0) begin bad++; $display("FAIL stall_data changes=%0d got=%0d exp=%0d", frozen_err, data_out, held); end
    total++; if (val_err != 0) begin bad++; $display("FAIL stall_val errors=%0d exp=0", val_err); end
    total++; if (rdy_err != 0) begin bad++; $display("FAIL stall_rdy errors=%0d exp=0", rdy_err); end
    en = 1'b1;
    cyc();
    total++; if (val_out !== 1'b1) begin bad++; $display("FAIL stall_resume_val got=%b exp=1", val_out); end
    n = 1;
    for (int i = 0; i < 100; i++) begin if (rdy === 1'b1) break; cyc(); n++; end
    total++; if (n != 40) begin bad++; $display("FAIL stall_cnt_frozen edges_to_slot=%0d exp=40", n); end
  endtask

  task automatic test_clamp();
    int n, rdy_err;
    rst = 1'b1; rate = 7'd0; val_in = 1'b1; en = 1'b1;
    cyc();
    rst = 1'b0;
    rdy_err = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (rdy !== 1'b1) rdy_err++; end
    total++; if (rdy_err != 0) begin bad++; $display("FAIL clamp_zero rdy_low_cycles=%0d exp=0", rdy_err); end
    rst = 1'b1; rate = 7'd100;
    cyc();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin cyc(); n++; if (rdy === 1'b1) break; end
    total++; if (n != 64) begin bad++; $display("FAIL clamp_max period=%0d exp=64", n); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rate = 7'd64; data_in = '0; val_in = 1'b0;
    test_reset();
    test_dc_max();
    test_reset_mid();
    test_dc_r32();
    test_underrun();
    test_rate_change();
    test_stall();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
